csr_trap_unit: RTL and testbench

//  Trap sequencer between the commit stage and the machine CSR file. Takes commit-time exception info,

---
 rtl/csr_trap_unit.sv | 178 +++++++++++++++++
 tb/tb_csr_trap_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_trap_unit.sv
// Trap sequencer: turns commit-time exceptions, interrupts and mret into ordered CSR writes and a fetch redirect.
// Optional feature: define CSR_TRAP_VECTORED_EN to honour vectored mtvec mode for interrupts.
module csr_trap_unit #(
    parameter int XLEN    = 64,
    parameter int CAUSE_W = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmt_valid,
    output logic               cmt_ready,
    input  logic [XLEN-1:0]    cmt_pc,
    input  logic               cmt_exc,
    input  logic [CAUSE_W-1:0] cmt_exc_code,
    input  logic [XLEN-1:0]    cmt_tval,
    input  logic               cmt_mret,
    input  logic [XLEN-1:0]    irq_pending,
    input  logic [XLEN-1:0]    mstatus_i,
    input  logic [XLEN-1:0]    mtvec_i,
    input  logic [XLEN-1:0]    mepc_i,
    output logic               csr_we,
    output logic [XLEN-1:0]    mepc_o,
    output logic [XLEN-1:0]    mcause_o,
    output logic [XLEN-1:0]    mtval_o,
    output logic [XLEN-1:0]    mstatus_o,
    output logic [1:0]         priv_o,
    output logic               redirect_valid,
    output logic [XLEN-1:0]    redirect_pc
);

    localparam int         MIE_BIT  = 3;
    localparam int         MPIE_BIT = 7;
    localparam int         MPP_LO   = 11;
    localparam logic [1:0] PRIV_M   = 2'b11;
    localparam logic [1:0] PRIV_U   = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRAP_WR,
        ST_REDIRECT
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [1:0]          r_priv;
    logic [1:0]          r_priv_next;
    logic [XLEN-1:0]     r_mepc;
    logic [XLEN-1:0]     r_mcause;
    logic [XLEN-1:0]     r_mtval;
    logic [XLEN-1:0]     r_mstatus;
    logic [XLEN-1:0]     r_redirect_pc;

    logic [2:0]          w_irq_sel;
    logic [CAUSE_W-1:0]  w_irq_code;
    logic                w_irq_take;
    logic                w_trap_take;
    logic                w_accept;
    logic [CAUSE_W-1:0]  w_cause_code;
    logic [XLEN-1:0]     w_mcause;
    logic [XLEN-1:0]     w_trap_base;
    logic [XLEN-1:0]     w_trap_target;
    logic [XLEN-1:0]     w_mstatus_trap;
    logic [XLEN-1:0]     w_mstatus_mret;
    logic                w_unused;

    // Only MEI/MSI/MTI are serviced; the remaining pending bits are deliberately ignored.
    assign w_irq_sel = {irq_pending[11], irq_pending[3], irq_pending[7]};
    assign w_unused  = ^{irq_pending, mtvec_i[1:0], cmt_pc[1:0]};

    always_comb begin
        // NOTE: every combinationally driven signal gets a default first so no path leaves it unassigned (no latch).
        w_irq_code = '0;
        if (irq_pending[11])
            w_irq_code = CAUSE_W'(11);
        else if (irq_pending[3])
            w_irq_code = CAUSE_W'(3);
        else if (irq_pending[7])
            w_irq_code = CAUSE_W'(7);
    end

    assign w_irq_take   = cmt_valid & (|w_irq_sel) & (mstatus_i[MIE_BIT] | (r_priv != PRIV_M));
    assign w_trap_take  = w_irq_take | (cmt_valid & cmt_exc);
    assign w_accept     = cmt_valid & cmt_ready & (w_trap_take | cmt_mret);
    assign w_cause_code = w_irq_take ? w_irq_code : cmt_exc_code;
    assign w_mcause     = {w_irq_take, {(XLEN-1-CAUSE_W){1'b0}}, w_cause_code};
    assign w_trap_base  = {mtvec_i[XLEN-1:2], 2'b00};

`ifdef CSR_TRAP_VECTORED_EN
    assign w_trap_target = (w_irq_take && (mtvec_i[1:0] == 2'b01))
                         ? w_trap_base + (XLEN'(w_irq_code) << 2)
                         : w_trap_base;
`else
    assign w_trap_target = w_trap_base;
`endif

    always_comb begin
        w_mstatus_trap                   = mstatus_i;
        w_mstatus_trap[MPIE_BIT]         = mstatus_i[MIE_BIT];
        w_mstatus_trap[MIE_BIT]          = 1'b0;
        w_mstatus_trap[MPP_LO +: 2]      = r_priv;

        w_mstatus_mret                   = mstatus_i;
        w_mstatus_mret[MIE_BIT]          = mstatus_i[MPIE_BIT];
        w_mstatus_mret[MPIE_BIT]         = 1'b1;
        w_mstatus_mret[MPP_LO +: 2]      = PRIV_U;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next   = r_state;
        cmt_ready      = 1'b0;
        csr_we         = 1'b0;
        redirect_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cmt_ready = 1'b1;
                if (w_accept)
                    w_state_next = ST_TRAP_WR;
            end
            ST_TRAP_WR: begin
                csr_we       = 1'b1;
                w_state_next = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                redirect_valid = 1'b1;
                w_state_next   = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Everything the sequence needs is captured at accept, so later input changes cannot disturb it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_priv        <= PRIV_M;
            r_priv_next   <= PRIV_M;
            r_mepc        <= '0;
            r_mcause      <= '0;
            r_mtval       <= '0;
            r_mstatus     <= '0;
            r_redirect_pc <= '0;
        end else begin
            if (w_accept) begin
                if (w_trap_take) begin
                    r_mepc        <= {cmt_pc[XLEN-1:2], 2'b00};
                    r_mcause      <= w_mcause;
                    r_mtval       <= w_irq_take ? '0 : cmt_tval;
                    r_mstatus     <= w_mstatus_trap;
                    r_priv_next   <= PRIV_M;
                    r_redirect_pc <= w_trap_target;
                end else begin
                    // mret keeps the last written mcause and rewrites mepc with its current value.
                    r_mepc        <= mepc_i;
                    r_mtval       <= '0;
                    r_mstatus     <= w_mstatus_mret;
                    r_priv_next   <= mstatus_i[MPP_LO +: 2];
                    r_redirect_pc <= mepc_i;
                end
            end
            if (r_state == ST_TRAP_WR)
                r_priv <= r_priv_next;
        end
    end

    assign mepc_o      = r_mepc;
    assign mcause_o    = r_mcause;
    assign mtval_o     = r_mtval;
    assign mstatus_o   = r_mstatus;
    assign priv_o      = r_priv;
    assign redirect_pc = r_redirect_pc;

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed self-checking bench for csr_trap_unit; expected CSR writes go through a scoreboard queue.
// Expected redirect targets follow CSR_TRAP_VECTORED_EN when it is defined for the build.
module tb_csr_trap_unit;

    localparam int XLEN    = 64;
    localparam int CAUSE_W = 6;

    logic               clk;
    logic               reset;
    logic               cmt_valid;
    logic               cmt_ready;
    logic [XLEN-1:0]    cmt_pc;
    logic               cmt_exc;
    logic [CAUSE_W-1:0] cmt_exc_code;
    logic [XLEN-1:0]    cmt_tval;
    logic               cmt_mret;
    logic [XLEN-1:0]    irq_pending;
    logic [XLEN-1:0]    mstatus_i;
    logic [XLEN-1:0]    mtvec_i;
    logic [XLEN-1:0]    mepc_i;
    logic               csr_we;
    logic [XLEN-1:0]    mepc_o;
    logic [XLEN-1:0]    mcause_o;
    logic [XLEN-1:0]    mtval_o;
    logic [XLEN-1:0]    mstatus_o;
    logic [1:0]         priv_o;
    logic               redirect_valid;
    logic [XLEN-1:0]    redirect_pc;

    typedef struct {
        logic [63:0] mepc;
        logic [63:0] mcause;
        logic [63:0] mtval;
        logic [63:0] mstatus;
        logic [63:0] target;
        logic [1:0]  priv;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    csr_trap_unit #(.XLEN(XLEN), .CAUSE_W(CAUSE_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .cmt_valid      (cmt_valid),
        .cmt_ready      (cmt_ready),
        .cmt_pc         (cmt_pc),
        .cmt_exc        (cmt_exc),
        .cmt_exc_code   (cmt_exc_code),
        .cmt_tval       (cmt_tval),
        .cmt_mret       (cmt_mret),
        .irq_pending    (irq_pending),
        .mstatus_i      (mstatus_i),
        .mtvec_i        (mtvec_i),
        .mepc_i         (mepc_i),
        .csr_we         (csr_we),
        .mepc_o         (mepc_o),
        .mcause_o       (mcause_o),
        .mtval_o        (mtval_o),
        .mstatus_o      (mstatus_o),
        .priv_o         (priv_o),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [63:0] mepc, input logic [63:0] mcause, input logic [63:0] mtval,
                            input logic [63:0] mstatus, input logic [63:0] target, input logic [1:0] priv);
        exp_t e;
        e.mepc    = mepc;
        e.mcause  = mcause;
        e.mtval   = mtval;
        e.mstatus = mstatus;
        e.target  = target;
        e.priv    = priv;
        sb_q.push_back(e);
    endtask

    // Presents one commit for a single edge, then scrambles every accept-time input.
    task automatic fire(input logic [63:0] pc, input logic exc, input logic [5:0] code,
                        input logic [63:0] tval, input logic mret, input logic [63:0] irq);
        @(negedge clk);
        cmt_valid    = 1'b1;
        cmt_pc       = pc;
        cmt_exc      = exc;
        cmt_exc_code = code;
        cmt_tval     = tval;
        cmt_mret     = mret;
        irq_pending  = irq;
        @(posedge clk);
        #1;
        cmt_valid    = 1'b0;
        cmt_pc       = '1;
        cmt_exc      = 1'b0;
        cmt_exc_code = '0;
        cmt_tval     = '1;
        cmt_mret     = 1'b0;
        irq_pending  = 64'h888;
        mstatus_i    = ~mstatus_i;
        mtvec_i      = 64'hDEAD_0001;
        mepc_i       = 64'h0000_BAD0;
    endtask

    // Follows the sequence after an accept: CSR write at N+1, redirect at N+2, ready again at N+3.
    task automatic run_event(input string tag);
        exp_t e;
        @(negedge clk);
        check({tag, ".csr_we"}, 64'(csr_we), 64'd1);
        check({tag, ".ready_n1"}, 64'(cmt_ready), 64'd0);
        if (sb_q.size() == 0) begin
            check({tag, ".sb_nonempty"}, 64'd0, 64'd1);
        end else begin
            e = sb_q.pop_front();
            check({tag, ".mepc"}, mepc_o, e.mepc);
            check({tag, ".mcause"}, mcause_o, e.mcause);
            check({tag, ".mtval"}, mtval_o, e.mtval);
            check({tag, ".mstatus"}, mstatus_o, e.mstatus);
            @(negedge clk);
            check({tag, ".redir_v"}, 64'(redirect_valid), 64'd1);
            check({tag, ".redir_pc"}, redirect_pc, e.target);
            check({tag, ".priv"}, 64'(priv_o), 64'(e.priv));
            check({tag, ".ready_n2"}, 64'(cmt_ready), 64'd0);
            check({tag, ".csr_we_n2"}, 64'(csr_we), 64'd0);
            @(negedge clk);
            check({tag, ".ready_n3"}, 64'(cmt_ready), 64'd1);
            check({tag, ".redir_n3"}, 64'(redirect_valid), 64'd0);
        end
    endtask

    initial begin
        reset        = 1'b1;
        cmt_valid    = 1'b0;
        cmt_pc       = '0;
        cmt_exc      = 1'b0;
        cmt_exc_code = '0;
        cmt_tval     = '0;
        cmt_mret     = 1'b0;
        irq_pending  = '0;
        mstatus_i    = '0;
        mtvec_i      = '0;
        mepc_i       = '0;
        repeat (2) @(negedge clk);
        check("rst.ready", 64'(cmt_ready), 64'd1);
        check("rst.csr_we", 64'(csr_we), 64'd0);
        check("rst.redir", 64'(redirect_valid), 64'd0);
        check("rst.priv", 64'(priv_o), 64'd3);
        check("rst.mepc", mepc_o, 64'd0);
        check("rst.mcause", mcause_o, 64'd0);
        check("rst.mtval", mtval_o, 64'd0);
        check("rst.mstatus", mstatus_o, 64'd0);
        check("rst.redir_pc", redirect_pc, 64'd0);
        reset = 1'b0;

        // Plain commit passes through with no sequence.
        @(negedge clk);
        cmt_valid = 1'b1;
        cmt_pc    = 64'h8000_0000;
        @(negedge clk);
        cmt_valid = 1'b0;
        check("plain.ready", 64'(cmt_ready), 64'd1);
        check("plain.csr_we", 64'(csr_we), 64'd0);

        // Synchronous exception, code 2.
        mstatus_i = 64'h0000_0000_0002_0008;
        mtvec_i   = 64'h8000_0100;
        push_exp(64'h8000_0010, 64'd2, 64'h13, 64'h0000_0000_0002_1880, 64'h8000_0100, 2'b11);
        fire(64'h8000_0010, 1'b1, 6'd2, 64'h13, 1'b0, 64'h0);
        run_event("exc2");

        // MTI + MEI pending with an exception: MEI wins, mtval cleared, mepc low bits cleared.
        mstatus_i = 64'h8;
        mtvec_i   = 64'h8000_0101;
`ifdef CSR_TRAP_VECTORED_EN
        push_exp(64'h8000_0044, 64'h8000_0000_0000_000B, 64'h0, 64'h1880, 64'h8000_012C, 2'b11);
`else
        push_exp(64'h8000_0044, 64'h8000_0000_0000_000B, 64'h0, 64'h1880, 64'h8000_0100, 2'b11);
`endif
        fire(64'h8000_0046, 1'b1, 6'd5, 64'h55, 1'b0, 64'h880);
        run_event("irq_mei");

        // Machine mode with mie=0 masks MSI.
        mstatus_i = 64'h0;
        @(negedge clk);
        cmt_valid   = 1'b1;
        cmt_pc      = 64'h8000_0060;
        irq_pending = 64'h8;
        @(negedge clk);
        cmt_valid   = 1'b0;
        irq_pending = 64'h0;
        check("mask.ready", 64'(cmt_ready), 64'd1);
        check("mask.csr_we", 64'(csr_we), 64'd0);
        @(negedge clk);
        check("mask.csr_we2", 64'(csr_we), 64'd0);

        // mret back to user mode; mcause keeps the last written value.
        mstatus_i = 64'h80;
        mepc_i    = 64'h8000_0200;
        push_exp(64'h8000_0200, 64'h8000_0000_0000_000B, 64'h0, 64'h88, 64'h8000_0200, 2'b00);
        fire(64'h8000_0070, 1'b0, 6'd0, 64'h77, 1'b1, 64'h0);
        run_event("mret_u");

        // User mode takes MSI even with mie=0; upper mstatus bits pass through.
        mstatus_i = 64'h0000_000A_0000_0000;
        mtvec_i   = 64'h8000_0101;
`ifdef CSR_TRAP_VECTORED_EN
        push_exp(64'h8000_0300, 64'h8000_0000_0000_0003, 64'h0, 64'h0000_000A_0000_0000, 64'h8000_010C, 2'b11);
`else
        push_exp(64'h8000_0300, 64'h8000_0000_0000_0003, 64'h0, 64'h0000_000A_0000_0000, 64'h8000_0100, 2'b11);
`endif
        fire(64'h8000_0300, 1'b0, 6'd0, 64'h99, 1'b0, 64'h8);
        run_event("irq_msi_u");

        // Exception together with mret: exception path only, vectored mode ignored for exceptions.
        mstatus_i = 64'h8;
        mtvec_i   = 64'h8000_0101;
        mepc_i    = 64'h8000_0900;
        push_exp(64'h8000_0400, 64'd3, 64'h400, 64'h1880, 64'h8000_0100, 2'b11);
        fire(64'h8000_0400, 1'b1, 6'd3, 64'h400, 1'b1, 64'h0);
        run_event("exc_mret");

        // Second mret returns to user mode so the reset case below starts from priv=U.
        mstatus_i = 64'h0;
        mepc_i    = 64'h8000_0500;
        push_exp(64'h8000_0500, 64'd3, 64'h0, 64'h80, 64'h8000_0500, 2'b00);
        fire(64'h8000_0080, 1'b0, 6'd0, 64'h0, 1'b1, 64'h0);
        run_event("mret_u2");

        // Reset while in TRAP_WR: immediate return to reset values, no redirect afterwards.
        mstatus_i = 64'h8;
        mtvec_i   = 64'h8000_0100;
        fire(64'h8000_0600, 1'b1, 6'd4, 64'h600, 1'b0, 64'h0);
        @(negedge clk);
        check("rstmid.csr_we_pre", 64'(csr_we), 64'd1);
        check("rstmid.priv_pre", 64'(priv_o), 64'd0);
        reset = 1'b1;
        #1;
        check("rstmid.csr_we", 64'(csr_we), 64'd0);
        check("rstmid.priv", 64'(priv_o), 64'd3);
        check("rstmid.ready", 64'(cmt_ready), 64'd1);
        check("rstmid.mepc", mepc_o, 64'd0);
        check("rstmid.redir_pc", redirect_pc, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rstmid.redir%0d", i), 64'(redirect_valid), 64'd0);
            check($sformatf("rstmid.we%0d", i), 64'(csr_we), 64'd0);
        end

        check("sb.empty", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
